// File: rtl/filter_gen_sched.sv
// filter_gen_sched
//   Sequencer for the filter-repeat datapath (8-deep weight shift chain,
//   reg5 input mux, 9:1 output mux). Loads one 8-tap filter through a
//   valid/ready handshake, then replays it w0..w7 for repeat_cnt passes.
//   Holds the datapath output register while downstream is stalled.
//
//   Handshake: a weight transfers on a rising edge where weight_valid and
//   weight_ready are both 1. weight_ready is high for every LOAD cycle and
//   does not depend on weight_valid. en is high exactly on transfer cycles.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          begin a job (sampled only in IDLE)
//   repeat_cnt     number of replay passes, latched on accepted start
//   weight_valid   weight present on the datapath filter input
//   weight_ready   scheduler accepts a weight this cycle
//   out_stall      downstream cannot take a weight this cycle
//   en             datapath shift-register enable
//   muxcontrol1    datapath reg5 input select, tied 0 (linear chain)
//   muxout         output mux select: 0=filter in, 1..8=reg1..reg8, 15=hold
//   out_valid      repeatedfil holds a valid replayed weight this cycle
//   out_last       with out_valid: w7 of the final pass
//   busy           high in LOAD, REPLAY and DONE
//   done           one-cycle pulse when a job ends
//   state_dbg      current FSM state (debug observation)
//   stall_cycles   (FILTER_SCHED_STALL_CNT_EN only) saturating count of
//                  REPLAY cycles with out_stall=1
//
// Configuration macro: FILTER_SCHED_STALL_CNT_EN

module filter_gen_sched #(
    parameter int NUM_TAPS = 8,
    parameter int PASS_W   = 8,
    parameter int SEL_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PASS_W-1:0] repeat_cnt,
    input  logic              weight_valid,
    output logic              weight_ready,
    input  logic              out_stall,
    output logic              en,
    output logic              muxcontrol1,
    output logic [SEL_W-1:0]  muxout,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
`ifdef FILTER_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REPLAY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] SEL_HOLD = '1;
    localparam logic [2:0]       TAP_MAX  = 3'(NUM_TAPS - 1);

    state_t            state;
    logic [PASS_W-1:0] rpt_q;
    logic [PASS_W-1:0] pass_cnt;
    logic [2:0]        tap_cnt;
    logic [2:0]        load_cnt;

    logic issue;
    logic last_tap;

    // A tap is issued in every unstalled REPLAY cycle.
    assign issue = (state == REPLAY) && !out_stall;
    // Compare against repeat_cnt-1 before incrementing so 255 passes never
    // needs a 9th counter bit.
    assign last_tap = (tap_cnt == TAP_MAX) && (pass_cnt == rpt_q - 1'b1);

    // reg8 holds w0 after loading, so tap t lives in reg(8-t).
    assign muxout      = issue ? (SEL_W'(NUM_TAPS) - {1'b0, tap_cnt}) : SEL_HOLD;
    assign en          = weight_ready && weight_valid;
    assign muxcontrol1 = 1'b0;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rpt_q        <= '0;
            pass_cnt     <= '0;
            tap_cnt      <= '0;
            load_cnt     <= '0;
            weight_ready <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Output register of the datapath lags the select by one cycle.
            out_valid <= issue;
            out_last  <= issue && last_tap;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rpt_q        <= repeat_cnt;
                        tap_cnt      <= '0;
                        pass_cnt     <= '0;
                        load_cnt     <= '0;
                        weight_ready <= 1'b1;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (weight_valid) begin
                        load_cnt <= load_cnt + 3'd1;
                        if (load_cnt == TAP_MAX) begin
                            weight_ready <= 1'b0;
                            tap_cnt      <= '0;
                            pass_cnt     <= '0;
                            if (rpt_q == '0) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= REPLAY;
                            end
                        end
                    end
                end
                REPLAY: begin
                    if (!out_stall) begin
                        if (last_tap) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (tap_cnt == TAP_MAX) begin
                            tap_cnt  <= '0;
                            pass_cnt <= pass_cnt + 1'b1;
                        end else begin
                            tap_cnt <= tap_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FILTER_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
        end else if ((state == REPLAY) && out_stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filter_gen_sched.sv
// Testbench for filter_gen_sched. Includes a behavioural model of the
// filter-repeat datapath (shift chain + output mux + output register)
// driven by the scheduler outputs; the expected replay stream is built
// from the loaded weights and the pass count.

module tb_filter_gen_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] repeat_cnt;
    logic       weight_valid;
    logic       weight_ready;
    logic       out_stall;
    logic       en;
    logic       muxcontrol1;
    logic [3:0] muxout;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;
`ifdef FILTER_SCHED_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    logic [7:0] filter_in;
    logic [7:0] chain [1:8];
    logic [7:0] repeatedfil;

    logic [7:0] wts [8];
    logic [7:0] exp_q [$];
    int n_pass = 0;
    int n_chk  = 0;

    filter_gen_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .repeat_cnt   (repeat_cnt),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .out_stall    (out_stall),
        .en           (en),
        .muxcontrol1  (muxcontrol1),
        .muxout       (muxout),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
`ifdef FILTER_SCHED_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model: shift chain and registered 9:1 output mux.
    always @(posedge clk) begin
        if (en) begin
            for (int i = 8; i >= 2; i--) chain[i] <= chain[i-1];
            chain[1] <= filter_in;
        end
        if (muxout == 4'd0) repeatedfil <= filter_in;
        else if (muxout <= 4'd8) repeatedfil <= chain[muxout];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_en"}, 16'(en), 16'd0);
        chk({tag, "_weight_ready"}, 16'(weight_ready), 16'd0);
        chk({tag, "_muxcontrol1"}, 16'(muxcontrol1), 16'd0);
        chk({tag, "_muxout"}, 16'(muxout), 16'hF);
        chk({tag, "_out_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_out_last"}, 16'(out_last), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_done"}, 16'(done), 16'd0);
`ifdef FILTER_SCHED_STALL_CNT_EN
        chk({tag, "_stall_cycles"}, stall_cycles, 16'd0);
`endif
    endtask

    // Runs one job starting at a negedge in IDLE; returns at a negedge in IDLE.
    // gap_mode: 0 back-to-back, 1 alternate 1/0, 2 random.
    task automatic run_job(input int rpt, input int gap_mode, input int stall_pct,
                           input int stall_at, input int stall_len,
                           input int abort_at, input bit start_in_done);
        int k, idx, total, outs, cyc, stall_left, stall_total;
        bit v, hs, stall, prev_issue, prev_last, got;
        logic [7:0] last_val, e;
        total = rpt * 8;
        exp_q.delete();
        for (int p = 0; p < rpt; p++)
            for (int t = 0; t < 8; t++) exp_q.push_back(wts[t]);

        start = 1'b1;
        repeat_cnt = 8'(rpt);
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 16'(busy), 16'd1);
        chk("load_ready", 16'(weight_ready), 16'd1);

        k = 0;
        cyc = 0;
        while (k < 8) begin
            if (cyc >= 200) begin
                chk("load_timeout", 16'(k), 16'd8);
                return;
            end
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(99) >= 40);
            endcase
            weight_valid = v;
            filter_in = v ? wts[k] : 8'($urandom);
            #1;
            chk("en_load", 16'(en), 16'(v));
            hs = v && weight_ready;
            @(negedge clk);
            if (hs) k++;
            cyc++;
        end
        weight_valid = 1'b0;

        if (rpt == 0) begin
            chk("zero_done", 16'(done), 16'd1);
            chk("zero_out_valid", 16'(out_valid), 16'd0);
            chk("zero_busy", 16'(busy), 16'd1);
            start = start_in_done;
            repeat_cnt = 8'd5;
            @(negedge clk);
            start = 1'b0;
            chk("zero_idle_busy", 16'(busy), 16'd0);
            chk("zero_idle_done", 16'(done), 16'd0);
            @(negedge clk);
            chk("zero_start_ignored", 16'(busy), 16'd0);
            chk("zero_out_valid2", 16'(out_valid), 16'd0);
            return;
        end

        idx = 0;
        outs = 0;
        prev_issue = 0;
        prev_last = 0;
        got = 0;
        last_val = '0;
        stall_left = stall_len;
        stall_total = 0;
        cyc = 0;
        forever begin
            chk("out_valid", 16'(out_valid), 16'(prev_issue));
            if (prev_issue) begin
                e = exp_q.pop_front();
                chk("data", 16'(repeatedfil), 16'(e));
                chk("out_last", 16'(out_last), 16'(prev_last));
                chk("done", 16'(done), 16'(prev_last));
                last_val = e;
                got = 1;
                outs++;
            end else begin
                chk("done_idle", 16'(done), 16'd0);
                if (got) chk("hold", 16'(repeatedfil), 16'(last_val));
            end
            if (outs == abort_at) begin
                rst = 1'b1;
                out_stall = 1'b0;
                weight_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_reset_vals("abort");
                return;
            end
            if (idx == total) break;
            if (cyc >= 20000) begin
                chk("replay_timeout", 16'(idx), 16'(total));
                return;
            end
            if (idx == stall_at && stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                stall = ($urandom_range(99) < stall_pct);
            end
            out_stall = stall;
            weight_valid = 1'($urandom_range(1));
            filter_in = 8'($urandom);
            #1;
            chk("en_replay", 16'(en), 16'd0);
            chk("ready_replay", 16'(weight_ready), 16'd0);
            chk("busy_replay", 16'(busy), 16'd1);
            chk("muxcontrol1", 16'(muxcontrol1), 16'd0);
            if (stall) begin
                chk("muxout_stall", 16'(muxout), 16'hF);
                stall_total++;
                prev_issue = 0;
            end else begin
                chk("muxout_sel", 16'(muxout), 16'(8 - (idx % 8)));
                prev_issue = 1;
                prev_last = (idx == total - 1);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end

        out_stall = 1'b0;
        weight_valid = 1'b0;
        chk("done_busy", 16'(busy), 16'd1);
        chk("done_muxout", 16'(muxout), 16'hF);
        chk("out_count", 16'(outs), 16'(total));
`ifdef FILTER_SCHED_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, 16'(stall_total));
`endif
        start = start_in_done;
        @(negedge clk);
        start = 1'b0;
        chk("end_busy", 16'(busy), 16'd0);
        chk("end_done", 16'(done), 16'd0);
        chk("end_out_valid", 16'(out_valid), 16'd0);
`ifdef FILTER_SCHED_STALL_CNT_EN
        chk("stall_cycles_hold", stall_cycles, 16'(stall_total));
`endif
    endtask

    task automatic set_seq_wts();
        for (int i = 0; i < 8; i++) wts[i] = 8'h10 + 8'(i);
    endtask

    task automatic set_rand_wts();
        for (int i = 0; i < 8; i++) wts[i] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat_cnt = '0;
        weight_valid = 1'b0;
        out_stall = 1'b0;
        filter_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        // weight_valid in IDLE must not shift the chain
        weight_valid = 1'b1;
        #1;
        chk("idle_en", 16'(en), 16'd0);
        @(negedge clk);
        weight_valid = 1'b0;
        chk("idle_busy", 16'(busy), 16'd0);

        set_seq_wts();
        run_job(1, 0, 0, -1, 0, -1, 1'b0);   // single pass
        run_job(3, 0, 0, -1, 0, -1, 1'b1);   // three passes, start in DONE ignored
        run_job(1, 1, 0, -1, 0, -1, 1'b0);   // alternating weight_valid
        run_job(1, 0, 0, 3, 3, -1, 1'b0);    // 3-cycle stall after 3rd output
        run_job(2, 0, 0, 7, 2, -1, 1'b0);    // stall on the last tap of a pass
        run_job(1, 0, 0, 7, 4, -1, 1'b0);    // stall on the final tap
        run_job(0, 0, 0, -1, 0, -1, 1'b1);   // zero passes
        run_job(2, 0, 0, -1, 0, 2, 1'b0);    // reset at 2nd output
        run_job(1, 0, 0, -1, 0, -1, 1'b0);   // clean job after abort

        for (int j = 0; j < 6; j++) begin
            set_rand_wts();
            run_job(int'($urandom_range(1, 4)), 2, 30, -1, 0, -1, 1'($urandom_range(1)));
        end

        set_rand_wts();
        run_job(255, 2, 10, -1, 0, -1, 1'b0); // maximum pass count

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
